alu_decode_stage: RTL

- Registered ID/EX-side decode stage. Turns a 32-bit RV32I instruction into the one-hot ALU control, branch opcode and operand-select signals consumed by the execute-stage ALU.
- Sits between the IF/ID register and the execute stage.
- Holds one decoded instruction with a valid/ready handshake, and supports pipeline stall and flush.

---
 rtl/alu_decode_stage.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode_stage
// Purpose  : Registered RV32I decode stage between IF/ID and execute. Turns a
//            raw instruction into a one-hot ALU control word, branch compare
//            select, operand-select and memory/writeback flags, and holds one
//            decoded bundle behind a valid/ready handshake with stall/flush.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_valid/in_ready - upstream handshake, instr = raw instruction
//            flush             - kill held and incoming instruction
//            out_valid/out_ready - downstream handshake for the bundle
//            alu_ctrl          - one-hot op: ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND
//            bropcode/is_branch - branch compare select (3'b010 when not a branch)
//            alu_src_imm, imm  - B operand select and sign-extended immediate
//            rs1/rs2/rd        - register indices
//            reg_write, mem_read, mem_write, illegal - control flags
//            instr_q           - registered raw instruction (debug)
// Revision : 1.0 - initial release
// ============================================================================
module alu_decode_stage #(
    parameter int XLEN         = 32,
    parameter bit RESET_PC_NOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [9:0]      alu_ctrl,
    output logic [2:0]      bropcode,
    output logic            is_branch,
    output logic            alu_src_imm,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            illegal,
    output logic [31:0]     instr_q
);

    localparam logic [6:0]  c_OP_R      = 7'b0110011;
    localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
    localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]  c_F7_BASE   = 7'b0000000;
    localparam logic [6:0]  c_F7_ALT    = 7'b0100000;
    // Non-branch compare select; the ALU branch unit yields 0 for this code.
    localparam logic [2:0]  c_BR_NONE   = 3'b010;
    localparam logic [31:0] c_RST_INSTR = RESET_PC_NOP ? 32'h0000_0013 : 32'h0;

    // funct3 -> one-hot ALU op; alt selects SUB/SRA on the 000/101 slots.
    function automatic logic [9:0] f3_onehot(input logic [2:0] f3, input logic alt);
        logic [9:0] oh;
        oh = '0;
        case (f3)
            3'b000:  oh = alt ? 10'h002 : 10'h001;
            3'b001:  oh = 10'h004;
            3'b010:  oh = 10'h008;
            3'b011:  oh = 10'h010;
            3'b100:  oh = 10'h020;
            3'b101:  oh = alt ? 10'h080 : 10'h040;
            3'b110:  oh = 10'h100;
            default: oh = 10'h200;
        endcase
        return oh;
    endfunction

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic        w_load;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign w_load   = in_valid && in_ready;

    logic            w_legal;
    logic [9:0]      w_alu;
    logic [2:0]      w_br;
    logic            w_isb;
    logic            w_src;
    logic            w_rw;
    logic            w_mr;
    logic            w_mw;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_rs1;

    always_comb begin
        w_legal = 1'b1;
        w_alu   = '0;
        w_br    = c_BR_NONE;
        w_isb   = 1'b0;
        w_src   = 1'b0;
        w_rw    = 1'b0;
        w_mr    = 1'b0;
        w_mw    = 1'b0;
        w_imm   = '0;
        w_rs1   = instr[19:15];
        case (w_opcode)
            c_OP_R: begin
                w_legal = (w_f7 == c_F7_BASE) ||
                          ((w_f7 == c_F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                w_alu   = f3_onehot(w_f3, w_f7[5]);
                w_rw    = 1'b1;
            end
            c_OP_IMM: begin
                if (w_f3 == 3'b001) begin
                    w_legal = (w_f7 == c_F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_legal = (w_f7 == c_F7_BASE) || (w_f7 == c_F7_ALT);
                end
                w_alu = f3_onehot(w_f3, (w_f3 == 3'b101) && w_f7[5]);
                w_src = 1'b1;
                w_rw  = 1'b1;
                // Shifts carry only the shift amount; funct7 is not immediate data.
                w_imm = ((w_f3 == 3'b001) || (w_f3 == 3'b101)) ? {27'b0, instr[24:20]} : w_imm_i;
            end
            c_OP_LOAD: begin
                w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
                w_alu   = 10'h001;
                w_src   = 1'b1;
                w_mr    = 1'b1;
                w_rw    = 1'b1;
                w_imm   = w_imm_i;
            end
            c_OP_STORE: begin
                w_legal = (w_f3 <= 3'b010);
                w_alu   = 10'h001;
                w_src   = 1'b1;
                w_mw    = 1'b1;
                w_imm   = w_imm_s;
            end
            c_OP_BRANCH: begin
                w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_isb   = 1'b1;
                w_br    = w_f3;
                w_imm   = w_imm_b;
            end
            c_OP_LUI: begin
                w_alu = 10'h001;
                w_src = 1'b1;
                w_rw  = 1'b1;
                w_imm = {instr[31:12], 12'b0};
                w_rs1 = 5'd0;
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal encodings still travel down as a valid bundle so execute can
        // trap, but with every side-effecting control cleared.
        if (!w_legal) begin
            w_alu = '0;
            w_br  = c_BR_NONE;
            w_isb = 1'b0;
            w_src = 1'b0;
            w_rw  = 1'b0;
            w_mr  = 1'b0;
            w_mw  = 1'b0;
            w_imm = '0;
        end
        if (instr[11:7] == 5'd0) begin
            w_rw = 1'b0;
        end
    end

    logic            r_valid;
    logic [9:0]      r_alu;
    logic [2:0]      r_br;
    logic            r_isb;
    logic            r_src;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic            r_rw;
    logic            r_mr;
    logic            r_mw;
    logic            r_ill;
    logic [31:0]     r_instr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= 1'b0;
            r_alu   <= '0;
            r_br    <= c_BR_NONE;
            r_isb   <= 1'b0;
            r_src   <= 1'b0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_rw    <= 1'b0;
            r_mr    <= 1'b0;
            r_mw    <= 1'b0;
            r_ill   <= 1'b0;
            r_instr <= c_RST_INSTR;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_alu   <= w_alu;
            r_br    <= w_br;
            r_isb   <= w_isb;
            r_src   <= w_src;
            r_imm   <= w_imm;
            r_rs1   <= w_rs1;
            r_rs2   <= instr[24:20];
            r_rd    <= instr[11:7];
            r_rw    <= w_rw;
            r_mr    <= w_mr;
            r_mw    <= w_mw;
            r_ill   <= !w_legal;
            r_instr <= instr;
        end else if (out_ready) begin
            // Drain: only valid drops; the payload is left untouched.
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign alu_ctrl    = r_alu;
    assign bropcode    = r_br;
    assign is_branch   = r_isb;
    assign alu_src_imm = r_src;
    assign imm         = r_imm;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign reg_write   = r_rw;
    assign mem_read    = r_mr;
    assign mem_write   = r_mw;
    assign illegal     = r_ill;
    assign instr_q     = r_instr;

endmodule
`default_nettype wire
